feature_transform_sequencer: RTL and testbench

- Control/capture block on the far side of the combinational dot-product multiplier in the GCN feature-transform stage.
- Walks every (feature row, weight column) pair and issues row/column read requests to the feature and weight memories; those memories drive the multiplier.
- Captures each returned dot product into an internal FEATURE_ROWS x WEIGHT_COLS result buffer.
- Exposes the buffer through a registered read port for the aggregation stage.

---
 rtl/feature_transform_sequencer.sv | 161 ++++++++++++++++
 tb/tb_feature_transform_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/feature_transform_sequencer.sv
// feature_transform_sequencer
//   Sequencer and capture block for the GCN feature-transform stage. It walks
//   every (feature row, weight column) pair in row-major order and issues read
//   strobes to the feature and weight memories. The dot product that comes back
//   one cycle later is written into a FEATURE_ROWS x WEIGHT_COLS result buffer.
//   A registered read port lets the aggregation stage read that buffer.
//
//   Ports:
//     clk, reset          clock (rising edge), asynchronous active-high reset
//     start               run request, honoured in IDLE or DONE only
//     busy, done          busy in RUN/DRAIN; done held in DONE until next start
//     fm_rd_en/fm_rd_row  feature-memory read strobe and row index
//     wm_rd_en/wm_rd_col  weight-memory read strobe and column index
//     dot_product         multiplier result, valid the cycle after the strobe
//     res_rd_row/col      result buffer read address
//     res_rd_data         registered read data (1-cycle latency, 0 if out of range)
//     cycle_count         busy-cycle counter (only with FEATURE_TRANSFORM_PERF_CNT_EN)
//
//   Optional build macro: FEATURE_TRANSFORM_PERF_CNT_EN adds the 32-bit
//   saturating cycle_count output.
module feature_transform_sequencer #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int COL_W = (WEIGHT_COLS  > 1) ? $clog2(WEIGHT_COLS)  : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fm_rd_en,
  output logic [ROW_W-1:0]          fm_rd_row,
  output logic                      wm_rd_en,
  output logic [COL_W-1:0]          wm_rd_col,
  input  logic [DOT_PROD_WIDTH-1:0] dot_product,
  input  logic [ROW_W-1:0]          res_rd_row,
  input  logic [COL_W-1:0]          res_rd_col,
  output logic [DOT_PROD_WIDTH-1:0] res_rd_data
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
  ,
  output logic [31:0]               cycle_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);
  // One extra bit so the bound itself is representable for the range check.
  localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W + 1)'(FEATURE_ROWS);
  localparam logic [COL_W:0]   COLS_EXT = (COL_W + 1)'(WEIGHT_COLS);

  state_t state, state_nxt;

  logic [ROW_W-1:0] row_cnt, hold_row;
  logic [COL_W-1:0] col_cnt, hold_col;
  logic             last_pair;

  logic                      cap_vld_p0;
  logic [ROW_W-1:0]          cap_row_p0;
  logic [COL_W-1:0]          cap_col_p0;
  logic [DOT_PROD_WIDTH-1:0] result [FEATURE_ROWS][WEIGHT_COLS];
  logic                      rd_in_range;

  assign last_pair = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_pair) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign fm_rd_en = (state == RUN);
  assign wm_rd_en = (state == RUN);
  // Counters show the live pair while issuing; afterwards the last issued
  // pair is held so the memories see stable addresses.
  assign fm_rd_row = (state == RUN) ? row_cnt : hold_row;
  assign wm_rd_col = (state == RUN) ? col_cnt : hold_col;

  // Issue stage: row-major counters, back to (0,0) after the final pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      hold_row <= '0;
      hold_col <= '0;
    end else if (state == RUN) begin
      hold_row <= row_cnt;
      hold_col <= col_cnt;
      if (last_pair) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (col_cnt == LAST_COL) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + ROW_W'(1);
      end else begin
        col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  // p0: issued pair delayed one cycle to line up with the returning dot product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld_p0 <= 1'b0;
      cap_row_p0 <= '0;
      cap_col_p0 <= '0;
    end else begin
      cap_vld_p0 <= (state == RUN);
      cap_row_p0 <= row_cnt;
      cap_col_p0 <= col_cnt;
    end
  end

  assign rd_in_range = ({1'b0, res_rd_row} < ROWS_EXT) && ({1'b0, res_rd_col} < COLS_EXT);

  // Capture and read port. Reading before writing in the same edge returns
  // the old entry on a simultaneous read/capture of one location.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_rd_data <= '0;
      for (int r = 0; r < FEATURE_ROWS; r++)
        for (int c = 0; c < WEIGHT_COLS; c++)
          result[r][c] <= '0;
    end else begin
      res_rd_data <= rd_in_range ? result[res_rd_row][res_rd_col] : '0;
      if (cap_vld_p0) result[cap_row_p0][cap_col_p0] <= dot_product;
    end
  end

`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (start && ((state == IDLE) || (state == DONE))) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= sat_inc(cycle_count);
    end
  end
`endif

endmodule

// File: tb/tb_feature_transform_sequencer.sv
module tb_feature_transform_sequencer;
  localparam int R = 6;
  localparam int C = 3;
  localparam int N = R * C;
  localparam int NV = N + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fm_rd_en, wm_rd_en;
  logic [2:0]  fm_rd_row;
  logic [1:0]  wm_rd_col;
  logic [15:0] dot_product = '0;
  logic [2:0]  res_rd_row = '0;
  logic [1:0]  res_rd_col = '0;
  logic [15:0] res_rd_data;

  logic        s_start = 1'b0;
  logic        s_busy, s_done, s_fm_rd_en, s_wm_rd_en;
  logic [0:0]  s_fm_rd_row, s_wm_rd_col;
  logic [15:0] s_dot_product = '0;
  logic [0:0]  s_res_rd_row = '0;
  logic [0:0]  s_res_rd_col = '0;
  logic [15:0] s_res_rd_data;

`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
  logic [31:0] cycle_count, s_cycle_count;
`endif

  int off = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int row;
    int col;
    int exp;
  } vec_t;

  vec_t vecs[NV];
  vec_t exp_q[$];

  feature_transform_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fm_rd_en(fm_rd_en), .fm_rd_row(fm_rd_row), .wm_rd_en(wm_rd_en), .wm_rd_col(wm_rd_col),
    .dot_product(dot_product), .res_rd_row(res_rd_row), .res_rd_col(res_rd_col),
    .res_rd_data(res_rd_data)
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  feature_transform_sequencer #(.FEATURE_ROWS(1), .WEIGHT_COLS(1), .DOT_PROD_WIDTH(16)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .fm_rd_en(s_fm_rd_en), .fm_rd_row(s_fm_rd_row), .wm_rd_en(s_wm_rd_en), .wm_rd_col(s_wm_rd_col),
    .dot_product(s_dot_product), .res_rd_row(s_res_rd_row), .res_rd_col(s_res_rd_col),
    .res_rd_data(s_res_rd_data)
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
    , .cycle_count(s_cycle_count)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier model: result of the indices presented in the previous cycle.
  always @(posedge clk) begin
    dot_product   <= 16'(16 * int'(fm_rd_row) + int'(wm_rd_col) + off);
    s_dot_product <= 16'(16 * int'(s_fm_rd_row) + int'(s_wm_rd_col));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_table(input int o, input bit zero);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        vecs[r * C + c] = '{r, c, zero ? 0 : 16 * r + c + o};
    vecs[N]     = '{6, 0, 0};
    vecs[N + 1] = '{0, 3, 0};
    vecs[N + 2] = '{7, 3, 0};
  endtask

  // Pipelined read pass: address pushed each cycle, compared one cycle later.
  task automatic read_table(input string tag);
    vec_t e;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s_rd(%0d,%0d)", tag, e.row, e.col), 32'(res_rd_data), 32'(e.exp));
      end
      res_rd_row = 3'(vecs[i].row);
      res_rd_col = 2'(vecs[i].col);
      exp_q.push_back(vecs[i]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s_rd(%0d,%0d)", tag, e.row, e.col), 32'(res_rd_data), 32'(e.exp));
  endtask

  // One full run from start acceptance to done; prev00 is entry (0,0) before the run.
  task automatic run_check(input bit hold, input int prev00);
    int en_cnt;
    en_cnt = 0;
    start = 1'b1;
    res_rd_row = '0;
    res_rd_col = '0;
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (k <= N) begin
        check($sformatf("en_k%0d", k), 32'(fm_rd_en), 1);
        check($sformatf("row_k%0d", k), 32'(fm_rd_row), 32'((k - 1) / C));
        check($sformatf("col_k%0d", k), 32'(wm_rd_col), 32'((k - 1) % C));
      end else begin
        check("drain_en", 32'(fm_rd_en), 0);
      end
      check($sformatf("busy_k%0d", k), 32'(busy), 1);
      check($sformatf("done_k%0d", k), 32'(done), 0);
      check($sformatf("wm_en_k%0d", k), 32'(wm_rd_en), 32'(fm_rd_en));
      if (fm_rd_en) en_cnt++;
      if (k == 3) check("old_on_capture", 32'(res_rd_data), 32'(prev00));
      if (k == 4) check("new_after_capture", 32'(res_rd_data), 32'(off));
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
      if (k == 1) check("cc_cleared", cycle_count, 0);
`endif
    end
    @(negedge clk);
    check("done_end", 32'(done), 1);
    check("busy_end", 32'(busy), 0);
    check("en_end", 32'(fm_rd_en), 0);
    check("row_held", 32'(fm_rd_row), 32'(R - 1));
    check("col_held", 32'(wm_rd_col), 32'(C - 1));
    check("en_count", 32'(en_cnt), 32'(N));
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
    check("cc_done", cycle_count, 32'(N + 1));
`endif
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_en", 32'(fm_rd_en | wm_rd_en), 0);
    check("rst_idx", 32'({fm_rd_row, wm_rd_col}), 0);
    check("rst_data", 32'(res_rd_data), 0);
    @(negedge clk);
    reset = 1'b0;

    // Plain run with a one-cycle start pulse
    off = 0;
    run_check(1'b0, 0);
    fill_table(0, 1'b0);
    read_table("run1");

    // start held through a run, then immediate restart from DONE
    run_check(1'b1, 0);
    off = 1;
    run_check(1'b0, 0);
    fill_table(1, 1'b0);
    read_table("run2");

    // Reset at issue cycle 7
    off = 2;
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_en", 32'(fm_rd_en | wm_rd_en), 0);
    check("mid_rst_idx", 32'({fm_rd_row, wm_rd_col}), 0);
    check("mid_rst_data", 32'(res_rd_data), 0);
    reset = 1'b0;
    fill_table(0, 1'b1);
    read_table("cleared");
    run_check(1'b0, 0);
    fill_table(2, 1'b0);
    read_table("run3");

`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
    repeat (10) @(negedge clk);
    check("cc_frozen", cycle_count, 32'(N + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cc_restart", cycle_count, 0);
    repeat (N + 2) @(negedge clk);
`endif

    // 1x1 instance
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("s_en_k1", 32'(s_fm_rd_en), 1);
    check("s_busy_k1", 32'(s_busy), 1);
    @(negedge clk);
    check("s_en_k2", 32'(s_fm_rd_en), 0);
    check("s_busy_k2", 32'(s_busy), 1);
    check("s_done_k2", 32'(s_done), 0);
    @(negedge clk);
    check("s_done", 32'(s_done), 1);
    check("s_busy_end", 32'(s_busy), 0);
`ifdef FEATURE_TRANSFORM_PERF_CNT_EN
    check("s_cc", s_cycle_count, 2);
`endif
    s_res_rd_row = '0;
    s_res_rd_col = '0;
    @(negedge clk);
    check("s_rd(0,0)", 32'(s_res_rd_data), 0);
    s_res_rd_row = 1'b1;
    @(negedge clk);
    check("s_rd(1,0)", 32'(s_res_rd_data), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
